// File: rtl/inert_pkg.sv
// Shared definitions for the inertial sensor command sequencer.
// Holds the FSM state type, the sensor configuration command table and
// the yaw-rate read commands. All commands are {rw, addr[6:0], data[7:0]}.
package inert_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        RDL_ISSUE,
        RDL_WAIT,
        RDH_ISSUE,
        RDH_WAIT
    } inert_state_t;

    // Number of configuration writes issued after power-up.
    localparam int CFG_COUNT = 4;

    // Index of the final configuration write; its completion raises rdy.
    localparam logic [1:0] CFG_LAST_IDX = 2'd3;

    // Configuration writes, issued in order after the power-up wait.
    localparam logic [15:0] CFG_CMD [0:CFG_COUNT-1] = '{
        16'h0D02,
        16'h1053,
        16'h1150,
        16'h1460
    };

    // Reads of the yaw-rate low and high bytes (rw bit set).
    localparam logic [15:0] RD_YAW_L = 16'hA600;
    localparam logic [15:0] RD_YAW_H = 16'hA700;

    // True for the states that launch a SPI transaction.
    function automatic logic is_issue_state(input inert_state_t s);
        return (s == CFG_ISSUE) || (s == RDL_ISSUE) || (s == RDH_ISSUE);
    endfunction

endpackage

// File: rtl/inert_ctrl_int_sync.sv
// Brings the asynchronous sensor data-ready line into the clk domain
// and flags its rising edge for exactly one cycle.
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;
    logic ff3_q, ff3_d;

    // Shift the raw input through two synchronizer flops and one edge flop.
    always_comb begin
        ff1_d = async_in;
        ff2_d = ff1_q;
        ff3_d = ff2_q;
    end

    // Synchronizer chain registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            ff3_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
            ff3_q <= ff3_d;
        end
    end

    assign rise = ff2_q & ~ff3_q;

endmodule

// File: rtl/inert_ctrl.sv
// Command sequencer sitting in front of the 16-bit SPI master.
// Waits for sensor power-up, writes the configuration registers, then
// reads the two yaw-rate bytes on each data-ready interrupt and presents
// the assembled sample with a one-cycle valid strobe.
module inert_ctrl
    import inert_pkg::*;
#(
    parameter int INIT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        rdy
);

    localparam int TW = $clog2(INIT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(INIT_CYCLES - 1);

    inert_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          skip_q, skip_d;
    logic [7:0]    low_q, low_d;
    logic          wrt_q, wrt_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   yaw_q, yaw_d;
    logic          vld_q, vld_d;
    logic          rdy_q, rdy_d;

    logic          int_rise;
    logic          done_seen;
    logic          unused_rd_high;

    // Only the low byte of each SPI receive word carries sensor data.
    assign unused_rd_high = ^rd_data[15:8];

    int_sync u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (INT),
        .rise     (int_rise)
    );

    // A done level present in the first cycle after wrt belongs to the
    // previous transaction, so it is masked for that one cycle.
    assign done_seen = done & ~skip_q;

    // Next-state, counters, byte capture and registered output values.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        low_d     = low_q;
        yaw_d     = yaw_q;
        rdy_d     = rdy_q;
        cmd_d     = cmd_q;
        vld_d     = 1'b0;
        wrt_d     = 1'b0;
        skip_d    = wrt_q;

        if (int_rise && rdy_q && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            INIT_WAIT: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = CFG_ISSUE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CFG_ISSUE: begin
                state_d = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (done_seen) begin
                    if (idx_q == CFG_LAST_IDX) begin
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CFG_ISSUE;
                    end
                end
            end
            IDLE: begin
                if (int_rise || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = RDL_ISSUE;
                end
            end
            RDL_ISSUE: begin
                state_d = RDL_WAIT;
            end
            RDL_WAIT: begin
                if (done_seen) begin
                    low_d   = rd_data[7:0];
                    state_d = RDH_ISSUE;
                end
            end
            RDH_ISSUE: begin
                state_d = RDH_WAIT;
            end
            RDH_WAIT: begin
                if (done_seen) begin
                    yaw_d   = {rd_data[7:0], low_q};
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT_WAIT;
            end
        endcase

        // The command register loads on the edge entering an issue state,
        // so cmd is already stable throughout the wrt cycle and holds
        // afterwards until the next transaction.
        if (is_issue_state(state_d)) begin
            wrt_d = 1'b1;
            unique case (state_d)
                CFG_ISSUE: cmd_d = CFG_CMD[idx_d];
                RDL_ISSUE: cmd_d = RD_YAW_L;
                RDH_ISSUE: cmd_d = RD_YAW_H;
                default:   cmd_d = cmd_q;
            endcase
        end
    end

    // State, counters and output registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT_WAIT;
            timer_q   <= '0;
            idx_q     <= 2'd0;
            pending_q <= 1'b0;
            skip_q    <= 1'b0;
            low_q     <= 8'h00;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            yaw_q     <= 16'h0000;
            vld_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            skip_q    <= skip_d;
            low_q     <= low_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            yaw_q     <= yaw_d;
            vld_q     <= vld_d;
            rdy_q     <= rdy_d;
        end
    end

    assign wrt    = wrt_q;
    assign cmd    = cmd_q;
    assign yaw_rt = yaw_q;
    assign vld    = vld_q;
    assign rdy    = rdy_q;

endmodule

// File: tb/tb_inert_ctrl.sv
// Self-checking bench for inert_ctrl: a behavioural SPI master answers
// every wrt after a fixed latency, expected commands and samples flow
// through queues, and a monitor compares whatever the DUT presents.
module tb_inert_ctrl;

    localparam int INIT_CYCLES = 16;
    localparam int SLAVE_LAT   = 10;
    localparam int WRT_GAP     = SLAVE_LAT + 1;

    localparam logic [15:0] E_CFG0 = 16'h0D02;
    localparam logic [15:0] E_CFG1 = 16'h1053;
    localparam logic [15:0] E_CFG2 = 16'h1150;
    localparam logic [15:0] E_CFG3 = 16'h1460;
    localparam logic [15:0] E_RDL  = 16'hA600;
    localparam logic [15:0] E_RDH  = 16'hA700;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_in;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        rdy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] exp_cmd_q [$];
    logic [15:0] exp_yaw_q [$];
    int          vld_remaining = 0;
    int          rdl_seen = 0;
    int          rdh_seen = 0;

    inert_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (int_in),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .yaw_rt  (yaw_rt),
        .vld     (vld),
        .rdy     (rdy)
    );

    // Free-running clock and an edge counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural SPI master: takes wrt, drops done (late when stale_mode
    // is set, to model a leftover done level), and raises done with data
    // SLAVE_LAT edges later. Yaw bytes it hands out define the expected sample.
    logic        busy, clr_pend, stale_mode;
    int          lat;
    logic [15:0] cur_cmd;
    logic [7:0]  lo_save;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            rd_data  <= 16'h0000;
            busy     <= 1'b0;
            clr_pend <= 1'b0;
            lat      <= 0;
            cur_cmd  <= 16'h0000;
        end else begin
            clr_pend <= 1'b0;
            if (clr_pend) done <= 1'b0;
            if (wrt) begin
                busy    <= 1'b1;
                lat     <= 1;
                cur_cmd <= cmd;
                if (stale_mode) clr_pend <= 1'b1;
                else            done     <= 1'b0;
            end else if (busy) begin
                if (lat == SLAVE_LAT - 1) begin : respond
                    logic [7:0] b;
                    logic [7:0] junk;
                    b    = 8'($urandom);
                    junk = 8'($urandom);
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    rd_data <= {junk, b};
                    if (cur_cmd == E_RDL) lo_save <= b;
                    if (cur_cmd == E_RDH) exp_yaw_q.push_back({b, lo_save});
                end else begin
                    lat <= lat + 1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues wrt or pulses vld.
    logic [15:0] exp_c;
    logic [15:0] prev_cmd;
    logic        prev_vld;
    int          last_wrt_cycle, last_rdh_cycle, cfg_last_cycle;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld       = 1'b0;
            prev_cmd       = 16'h0000;
            last_wrt_cycle = -1000;
            last_rdh_cycle = -1000;
            cfg_last_cycle = -1000;
        end else begin
            if (wrt) begin
                if (exp_cmd_q.size() == 0) begin
                    reportFail("unexpected wrt", 32'(cmd), 32'hFFFF_FFFF);
                end else begin
                    exp_c = exp_cmd_q.pop_front();
                    checkOutput("cmd", 32'(cmd), 32'(exp_c));
                    checkOutput("rdy at wrt", 32'(rdy), 32'(exp_c == E_RDL || exp_c == E_RDH));
                    if (exp_c != E_CFG0 && exp_c != E_RDL)
                        checkOutput("wrt spacing", 32'(cycle - last_wrt_cycle), 32'(WRT_GAP));
                    if (exp_c == E_CFG3) cfg_last_cycle = cycle;
                    if (exp_c == E_RDL)  rdl_seen++;
                    if (exp_c == E_RDH) begin
                        rdh_seen++;
                        last_rdh_cycle = cycle;
                    end
                end
                last_wrt_cycle = cycle;
            end else if (cmd !== prev_cmd) begin
                reportFail("cmd changed without wrt", 32'(cmd), 32'(prev_cmd));
            end
            if (cycle == cfg_last_cycle + SLAVE_LAT)
                checkOutput("rdy before final done", 32'(rdy), 32'd0);
            if (cycle == cfg_last_cycle + SLAVE_LAT + 1)
                checkOutput("rdy after final done", 32'(rdy), 32'd1);
            if (vld) begin
                if (prev_vld) reportFail("vld width", 32'd2, 32'd1);
                checkOutput("vld latency", 32'(cycle - last_rdh_cycle), 32'(WRT_GAP));
                vld_remaining--;
                if (exp_yaw_q.size() == 0) reportFail("unexpected vld", 32'(yaw_rt), 32'hFFFF_FFFF);
                else                       checkOutput("yaw_rt", 32'(yaw_rt), 32'(exp_yaw_q.pop_front()));
            end
            prev_vld = vld;
            prev_cmd = cmd;
        end
    end

    task automatic pushConfig();
        exp_cmd_q.push_back(E_CFG0);
        exp_cmd_q.push_back(E_CFG1);
        exp_cmd_q.push_back(E_CFG2);
        exp_cmd_q.push_back(E_CFG3);
    endtask

    task automatic pulseInt();
        #($urandom_range(1, 4));
        int_in = 1'b1;
        repeat (2) @(negedge clk);
        int_in = 1'b0;
    endtask

    // Release reset and check the power-up wait, the config writes and rdy.
    task automatic bootAndConfigure(input logic int_during_init);
        int n, rel;
        pushConfig();
        @(negedge clk);
        rst = 1'b0;
        rel = cycle;
        if (int_during_init) begin
            repeat (2) @(negedge clk);
            pulseInt();
        end
        n = 0;
        while (!wrt && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wrt) reportFail("first wrt timeout", 32'(n), 32'(INIT_CYCLES));
        else      checkOutput("power-up wait", 32'(cycle - rel), 32'(INIT_CYCLES));
        n = 0;
        while (!rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rdy after config", 32'(rdy), 32'd1);
        checkOutput("config cmds consumed", 32'(exp_cmd_q.size()), 32'd0);
        repeat (40) @(negedge clk);
    endtask

    // kind 0: single read; kind 1: extra INT edges during the read;
    // kind 2: single read with stale done levels from the master.
    task automatic applyStimulus(input int kind);
        int n, seen0, extra;
        stale_mode = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        exp_cmd_q.push_back(E_RDL);
        exp_cmd_q.push_back(E_RDH);
        vld_remaining++;
        if (kind == 1) begin
            exp_cmd_q.push_back(E_RDL);
            exp_cmd_q.push_back(E_RDH);
            vld_remaining++;
        end
        seen0 = rdl_seen;
        pulseInt();
        if (kind == 1) begin
            n = 0;
            while (rdl_seen == seen0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (rdl_seen == seen0) reportFail("read start timeout", 32'(n), 32'd0);
            extra = $urandom_range(1, 3);
            for (int e = 0; e < extra; e++) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
                pulseInt();
            end
        end
        n = 0;
        while ((exp_cmd_q.size() != 0 || vld_remaining != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("read pairs outstanding", 32'(exp_cmd_q.size()), 32'd0);
        checkOutput("samples outstanding", 32'(vld_remaining), 32'd0);
        repeat (15) @(negedge clk);
    endtask

    // Main sequence.
    initial begin
        int n, seen0;
        rst        = 1'b1;
        int_in     = 1'b0;
        stale_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset wrt", 32'(wrt), 32'd0);
        checkOutput("reset cmd", 32'(cmd), 32'd0);
        checkOutput("reset yaw_rt", 32'(yaw_rt), 32'd0);
        checkOutput("reset vld", 32'(vld), 32'd0);
        checkOutput("reset rdy", 32'(rdy), 32'd0);

        bootAndConfigure(1'b1);

        applyStimulus(0);
        applyStimulus(1);
        applyStimulus(2);
        for (int i = 0; i < 8; i++) applyStimulus($urandom_range(0, 2));

        // Reset while the high-byte read is outstanding.
        stale_mode = 1'b0;
        exp_cmd_q.push_back(E_RDL);
        exp_cmd_q.push_back(E_RDH);
        vld_remaining++;
        seen0 = rdh_seen;
        pulseInt();
        n = 0;
        while (rdh_seen == seen0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rdh_seen == seen0) reportFail("high read timeout", 32'(n), 32'd0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid-read reset wrt", 32'(wrt), 32'd0);
        checkOutput("mid-read reset cmd", 32'(cmd), 32'd0);
        checkOutput("mid-read reset yaw_rt", 32'(yaw_rt), 32'd0);
        checkOutput("mid-read reset vld", 32'(vld), 32'd0);
        checkOutput("mid-read reset rdy", 32'(rdy), 32'd0);
        exp_cmd_q.delete();
        exp_yaw_q.delete();
        vld_remaining = 0;
        repeat (3) @(negedge clk);

        stale_mode = 1'b1;
        bootAndConfigure(1'b0);
        applyStimulus(0);
        applyStimulus(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
